// File: rtl/cpu_param_pkg.sv
// cpu_param_pkg: opcodes, FSM encoding and instruction field positions shared by cpu_param.
package cpu_param_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;
    localparam logic [4:0] OP_MOV  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_IN   = 5'd7;
    localparam logic [4:0] OP_OUT  = 5'd8;
    localparam logic [4:0] OP_JMP  = 5'd9;
    localparam logic [4:0] OP_JZ   = 5'd10;
    localparam logic [4:0] OP_JC   = 5'd11;
    localparam logic [4:0] OP_HALT = 5'd12;
    localparam int OP_LSB       = 27;
    localparam int RDST_LSB     = 22;
    localparam int RS1_LSB      = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RS2_LSB      = 11;
    localparam int IMM_LSB      = 0;
    function automatic logic is_alu(input logic [4:0] op);
        return op <= OP_NOT;
    endfunction
endpackage

// File: rtl/cpu_param_alu.sv
// cpu_param_alu: result and flag generation; carry only from ADD/SUB, zero from every ALU op.
module cpu_param_alu
    import cpu_param_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              carry,
    output logic              carry_we,
    output logic              zero,
    output logic              zero_we
);
    logic [DATA_W:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        res = op == OP_ADD ? sum[DATA_W-1:0] :
              op == OP_SUB ? diff[DATA_W-1:0] :
              op == OP_AND ? a & b :
              op == OP_OR  ? a | b :
              op == OP_XOR ? a ^ b :
              op == OP_NOT ? ~a : b;
        carry    = op == OP_SUB ? diff[DATA_W] : sum[DATA_W];
        carry_we = op == OP_ADD || op == OP_SUB;
        zero     = res == '0;
        zero_we  = is_alu(op);
    end
endmodule

// File: rtl/cpu_param.sv
// cpu_param: two-cycle-per-instruction register CPU with loadable instruction memory.
module cpu_param
    import cpu_param_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int GPR_N      = 8,
    parameter int IMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          start,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    output logic                          halted,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(GPR_N);
    state_t state, state_nx;
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] ir, imm32;
    logic [DATA_W-1:0] gpr [GPR_N];
    logic [DATA_W-1:0] a, b, res;
    logic [4:0] op;
    logic [RW-1:0] rd, rs1, rs2;
    logic cf, zf, alu_c, alu_cwe, alu_z, alu_zwe, exec, idle, taken, unused_bits;
    assign op    = ir[OP_LSB +: 5];
    assign rd    = ir[RDST_LSB +: RW];
    assign rs1   = ir[RS1_LSB +: RW];
    assign rs2   = ir[RS2_LSB +: RW];
    assign imm32 = {16'b0, ir[IMM_LSB +: 16]};
    assign a     = gpr[rs1];
    assign b     = ir[IMM_MODE_BIT] ? imm32[DATA_W-1:0] : gpr[rs2];
    assign exec  = state == S_EXEC;
    assign idle  = state == S_IDLE || state == S_HALT;
    assign taken = op == OP_JMP || (op == OP_JZ && zf) || (op == OP_JC && cf);
    assign unused_bits = ^{ir, imm32};
    cpu_param_alu #(.DATA_W(DATA_W)) u_alu (
        .op(op), .a(a), .b(b), .res(res),
        .carry(alu_c), .carry_we(alu_cwe), .zero(alu_z), .zero_we(alu_zwe)
    );
    always_ff @(posedge clk or negedge sys_rst)
        if (!sys_rst) state <= S_IDLE;
        else state <= state_nx;
    always_comb
        state_nx = idle ? (start ? S_FETCH : state) :
                   state == S_FETCH ? S_EXEC :
                   state == S_WAIT ? (din_valid ? S_FETCH : S_WAIT) :
                   op == OP_HALT ? S_HALT :
                   (op == OP_IN && !din_valid) ? S_WAIT : S_FETCH;
    always_comb begin
        din_ready = (exec || state == S_WAIT) && op == OP_IN && din_valid;
        halted    = state == S_HALT;
    end
    // Instruction memory survives reset so a program can be rerun.
    always_ff @(posedge clk)
        if (prog_we && idle) imem[prog_addr] <= prog_data;
    always_ff @(posedge clk or negedge sys_rst)
        if (!sys_rst) begin
            pc         <= '0;
            ir         <= '0;
            cf         <= 1'b0;
            zf         <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int i = 0; i < GPR_N; i++) gpr[i] <= '0;
        end else begin
            dout_valid <= exec && op == OP_OUT;
            if (idle && start) pc <= '0;
            if (state == S_FETCH) ir <= imem[pc];
            if ((exec && op != OP_IN) || din_ready) pc <= taken ? ir[AW-1:0] : pc + AW'(1);
            if (exec && alu_zwe) gpr[rd] <= res;
            if (din_ready) gpr[rd] <= din;
            if (exec && op == OP_OUT) dout <= a;
            if (exec && alu_cwe) cf <= alu_c;
            if (exec && alu_zwe) zf <= alu_z;
        end
endmodule

// File: doc/cpu_param.md
CPU_PARAM -- requirements
Module: cpu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: GPR and datapath width (8..32).
REQ-002 SHALL have parameter GPR_N, default 8: number of GPRs (power of 2, 2..32).
REQ-003 SHALL have parameter IMEM_DEPTH, default 16: instruction words (power of 2).
REQ-004 SHALL have port clk  in  1: single clock, rising edge.
REQ-005 SHALL have port sys_rst  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1: pulse; begins execution at PC=0 from IDLE or HALT.
REQ-007 SHALL have port prog_we  in  1: instruction memory write enable.
REQ-008 SHALL have port prog_addr  in  $clog2(IMEM_DEPTH): write address.
REQ-009 SHALL have port prog_data  in  32: instruction word.
REQ-010 SHALL have port din  in  DATA_W: input data.
REQ-011 SHALL have port din_valid  in  1: din holds valid data.
REQ-012 SHALL have port din_ready  out  1: CPU consumes din this cycle.
REQ-013 SHALL have port dout  out  DATA_W: last OUT value, held.
REQ-014 SHALL have port dout_valid  out  1: one-cycle pulse per OUT.
REQ-015 SHALL have port halted  out  1: high in HALT state.
REQ-016 SHALL have port pc  out  $clog2(IMEM_DEPTH): current PC.

Function
REQ-017 SHALL decode IR as: opcode[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], imm[15:0]; register fields use low $clog2(GPR_N) bits.
REQ-018 SHALL use second operand = imm_mode ? imm zero-extended/truncated to DATA_W : GPR[rsrc2].
REQ-019 SHALL implement FSM IDLE -> FETCH -> EXEC -> FETCH; EXEC -> WAIT_IN on IN without din_valid; EXEC -> HALT on HALT; IDLE/HALT -> FETCH on start.
REQ-020 SHALL load IR from imem[PC] in FETCH; execute and update PC in EXEC (2 cycles per instruction).
REQ-021 SHALL support opcodes 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT(rsrc1), 7 IN, 8 OUT(rsrc1), 9 JMP, 10 JZ, 11 JC, 12 HALT; all others are NOP.
REQ-022 SHALL compute results modulo 2^DATA_W; ADD sets carry = carry-out; SUB sets carry = borrow.
REQ-023 SHALL set zero flag on every ALU op (0-6) iff result == 0; flags unchanged by other ops.
REQ-024 SHALL take jump target = imm mod IMEM_DEPTH; untaken and non-jump ops use PC+1, wrapping IMEM_DEPTH-1 -> 0.
REQ-025 SHALL, for IN, assert din_ready and write GPR[rdst]=din in the first EXEC/WAIT_IN cycle with din_valid high, then proceed to FETCH.
REQ-026 SHALL, for OUT, register dout=GPR[rsrc1] and pulse dout_valid for exactly one cycle.
REQ-027 SHALL accept prog_we only in IDLE or HALT; ignore it elsewhere.
REQ-028 SHALL ignore start outside IDLE/HALT; start and prog_we in the same cycle both take effect.

Reset
REQ-029 SHALL on sys_rst low, immediately: state=IDLE, PC=0, IR=0, all GPRs=0, flags=0, dout=0, dout_valid=0, din_ready=0, halted=0.
REQ-030 SHALL not clear instruction memory on reset; reset mid-instruction abandons it with no GPR write.

Structure
REQ-031 SHALL place opcode constants, state encoding and IR field positions in shared package cpu_param_pkg.
REQ-032 SHALL implement ALU and flag generation in sub-module cpu_param_alu (parametrised by DATA_W).

Verification
REQ-033 SHALL cover: load MOV r1,#5; ADD r2,r1,#3; OUT r2; HALT; start -> dout=0x0008, one dout_valid pulse, halted=1.
REQ-034 SHALL cover: DATA_W=16, r1=0xFFFF, ADD #1 -> result 0x0000, zero=1, carry=1; JC taken to imm target.
REQ-035 SHALL cover: IN with din_valid low 5 cycles then din=0xAAAA valid -> stalls in WAIT_IN, single din_ready pulse, GPR[rdst]=0xAAAA.
REQ-036 SHALL cover: IMEM_DEPTH=16, NOPs from PC=15 -> PC wraps to 0; JMP #20 -> PC=4.
REQ-037 SHALL cover: sys_rst low during WAIT_IN -> all outputs/GPRs reset; prog_we while running ignored; memory retained, rerun after start identical.
REQ-038 SHALL cover: GPR_N=4, DATA_W=8 build runs scenario REQ-033 with identical results.
